// File: rtl/addr_decoder.sv
// Dock I/O address decoder: programmable base/mask/slot/op windows map CPU /IORQ cycles onto
// device slots and drive chip selects, data-bridge controls, the 0xFF driver and READY.
module addr_decoder #(
    parameter int          ADDR_W       = 8,
    parameter int          NUM_WIN      = 4,
    parameter int          NUM_SLOTS    = 5,
    parameter logic [7:0]  IRQ_CFG_BASE = 8'hC0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic                 irq_int_active,
    input  logic [2:0]           irq_int_slot,
    input  logic                 irq_vec_cycle,
    input  logic [NUM_SLOTS-1:0] dev_ready_n,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic                 ready_n,
    output logic                 io_r_w_,
    output logic                 data_oe_n,
    output logic                 data_dir,
    output logic                 ff_oe_n,
    output logic                 win_valid,
    output logic [3:0]           win_index,
    output logic [2:0]           sel_slot,
    output logic [NUM_SLOTS-1:0] cs_n
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state;

    logic [ADDR_W-1:0] win_base [NUM_WIN];
    logic [ADDR_W-1:0] win_mask [NUM_WIN];
    logic [7:0]        win_slot [NUM_WIN];
    logic [7:0]        win_op   [NUM_WIN];

    logic [NUM_WIN-1:0]   hit;
    logic                 nxt_hit;
    logic                 nxt_read;
    logic [2:0]           nxt_slot;
    logic [NUM_SLOTS-1:0] nxt_cs_n;

    // NOTE: the window table is a small register file, not a RAM, so every entry gets a reset
    // value; the power-up state must decode every cycle to slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                win_base[i] <= '0;
                win_mask[i] <= '0;
                win_slot[i] <= '0;
                win_op[i]   <= 8'hFF;
            end
        end else if (cfg_we && (cfg_addr < IRQ_CFG_BASE)) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cfg_addr == 8'(i))             win_base[i] <= cfg_wdata[ADDR_W-1:0];
                if (cfg_addr == 8'(NUM_WIN + i))   win_mask[i] <= cfg_wdata[ADDR_W-1:0];
                if (cfg_addr == 8'(2*NUM_WIN + i)) win_slot[i] <= cfg_wdata;
                if (cfg_addr == 8'(3*NUM_WIN + i)) win_op[i]   <= cfg_wdata;
            end
        end
    end

    // NOTE: every signal driven from always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            hit[i] = ((addr & win_mask[i]) == (win_base[i] & win_mask[i]))
                  && (win_op[i][7] || (win_op[i][0] == r_w_))
                  && (win_slot[i] < 8'(NUM_SLOTS));
        end
    end

    // Scan from the top down so the lowest-numbered hitting window has the last word.
    always_comb begin
        win_valid = 1'b0;
        win_index = '0;
        sel_slot  = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_valid = 1'b1;
                win_index = 4'(i);
                sel_slot  = win_slot[i][2:0];
            end
        end
    end

    // Resolution of the cycle being latched; vector fetches bypass the windows entirely.
    always_comb begin
        nxt_hit  = win_valid;
        nxt_read = r_w_;
        nxt_slot = sel_slot;
        if (irq_vec_cycle) begin
            nxt_read = 1'b1;
            nxt_slot = irq_int_slot;
            nxt_hit  = irq_int_active && ({1'b0, irq_int_slot} < 4'(NUM_SLOTS));
        end
        nxt_cs_n = '1;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (nxt_hit && (3'(s) == nxt_slot)) nxt_cs_n[s] = 1'b0;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop sees
    // the pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cs_n      <= '1;
            data_oe_n <= 1'b1;
            ff_oe_n   <= 1'b1;
            data_dir  <= 1'b0;
            io_r_w_   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!iorq_n) begin
                        state     <= ACTIVE;
                        cs_n      <= nxt_cs_n;
                        data_oe_n <= !nxt_hit;
                        ff_oe_n   <= !(!nxt_hit && nxt_read);
                        data_dir  <= nxt_hit && nxt_read;
                        io_r_w_   <= nxt_hit ? nxt_read : 1'b1;
                    end
                end
                ACTIVE: begin
                    if (iorq_n) begin
                        state     <= IDLE;
                        cs_n      <= '1;
                        data_oe_n <= 1'b1;
                        ff_oe_n   <= 1'b1;
                        data_dir  <= 1'b0;
                        io_r_w_   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The selected slot's live ready line; with no chip select asserted this is 1.
    assign ready_n = &(dev_ready_n | cs_n);

endmodule

// File: tb/tb_addr_decoder.sv
// Self-checking bench for addr_decoder: table-driven decode vectors with a scoreboard queue
// for the registered cycle outputs, plus hand-written wait-state, cfg and reset sequences.
module tb_addr_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic       iorq_n;
    logic       r_w_;
    logic       irq_int_active;
    logic [2:0] irq_int_slot;
    logic       irq_vec_cycle;
    logic [4:0] dev_ready_n;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       ready_n;
    logic       io_r_w_;
    logic       data_oe_n;
    logic       data_dir;
    logic       ff_oe_n;
    logic       win_valid;
    logic [3:0] win_index;
    logic [2:0] sel_slot;
    logic [4:0] cs_n;

    always #5 clk = ~clk;

    addr_decoder dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
        .irq_int_active(irq_int_active), .irq_int_slot(irq_int_slot),
        .irq_vec_cycle(irq_vec_cycle), .dev_ready_n(dev_ready_n), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .ready_n(ready_n), .io_r_w_(io_r_w_),
        .data_oe_n(data_oe_n), .data_dir(data_dir), .ff_oe_n(ff_oe_n),
        .win_valid(win_valid), .win_index(win_index), .sel_slot(sel_slot), .cs_n(cs_n)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic       rw;
        logic [4:0] rdy;
        logic       vec;
        logic       act;
        logic [2:0] islot;
        logic       e_valid;
        logic [3:0] e_idx;
        logic [2:0] e_sel;
        logic [4:0] e_cs;
        logic       e_oe;
        logic       e_ff;
        logic       e_dir;
        logic       e_rdy;
    } vec_t;

    typedef struct packed {
        logic [4:0] cs;
        logic       oe;
        logic       ff;
        logic       dir;
        logic       rdy;
    } exp_t;

    int   passed = 0;
    int   total  = 0;
    exp_t sb_q[$];
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] a, input logic rw, input logic [4:0] rdy,
                                input logic vec, input logic act, input logic [2:0] islot,
                                input logic ev, input logic [3:0] ei, input logic [2:0] es,
                                input logic [4:0] ecs, input logic eoe, input logic eff,
                                input logic edir, input logic erdy);
        vec_t v;
        v = '{a, rw, rdy, vec, act, islot, ev, ei, es, ecs, eoe, eff, edir, erdy};
        return v;
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle cs_n"},      32'(cs_n), 32'h1F);
        check({tag, " idle data_oe_n"}, 32'(data_oe_n), 32'd1);
        check({tag, " idle ff_oe_n"},   32'(ff_oe_n), 32'd1);
        check({tag, " idle ready_n"},   32'(ready_n), 32'd1);
        check({tag, " idle data_dir"},  32'(data_dir), 32'd0);
    endtask

    // One full /IORQ cycle: combinational decode check, scoreboard push, latch, pop, release.
    task automatic run_vec(input int n, input vec_t v);
        exp_t e;
        string tag;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        addr = v.addr; r_w_ = v.rw; dev_ready_n = v.rdy;
        irq_vec_cycle = v.vec; irq_int_active = v.act; irq_int_slot = v.islot;
        #1;
        check({tag, " win_valid"}, 32'(win_valid), 32'(v.e_valid));
        check({tag, " win_index"}, 32'(win_index), 32'(v.e_idx));
        check({tag, " sel_slot"},  32'(sel_slot),  32'(v.e_sel));
        sb_q.push_back('{v.e_cs, v.e_oe, v.e_ff, v.e_dir, v.e_rdy});
        iorq_n = 1'b0;
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " cs_n"},      32'(cs_n),      32'(e.cs));
            check({tag, " data_oe_n"}, 32'(data_oe_n), 32'(e.oe));
            check({tag, " ff_oe_n"},   32'(ff_oe_n),   32'(e.ff));
            check({tag, " data_dir"},  32'(data_dir),  32'(e.dir));
            check({tag, " ready_n"},   32'(ready_n),   32'(e.rdy));
        end
        @(negedge clk);
        iorq_n = 1'b1; irq_vec_cycle = 1'b0; dev_ready_n = 5'h1F;
        @(posedge clk); #1;
        check_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; addr = '0; iorq_n = 1'b1; r_w_ = 1'b1; irq_int_active = 1'b0;
        irq_int_slot = '0; irq_vec_cycle = 1'b0; dev_ready_n = 5'h1F;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        // addr rw rdy vec act islot | valid idx sel | cs oe ff dir rdy
        tbl[0]  = mk(8'h10, 0, 5'h1F, 0, 0, 0, 1, 0, 0, 5'h1E, 0, 1, 0, 1);
        tbl[1]  = mk(8'h10, 0, 5'h1E, 0, 0, 0, 1, 0, 0, 5'h1E, 0, 1, 0, 0);
        tbl[2]  = mk(8'h31, 1, 5'h1F, 0, 0, 0, 1, 2, 1, 5'h1D, 0, 1, 1, 1);
        tbl[3]  = mk(8'h77, 1, 5'h1F, 0, 0, 0, 0, 0, 0, 5'h1F, 1, 0, 0, 1);
        tbl[4]  = mk(8'h31, 0, 5'h1F, 0, 0, 0, 0, 0, 0, 5'h1F, 1, 1, 0, 1);
        tbl[5]  = mk(8'h25, 0, 5'h1F, 0, 0, 0, 1, 1, 1, 5'h1D, 0, 1, 0, 1);
        tbl[6]  = mk(8'h25, 1, 5'h1F, 0, 0, 0, 0, 0, 0, 5'h1F, 1, 0, 0, 1);
        tbl[7]  = mk(8'h00, 1, 5'h1F, 0, 0, 0, 1, 3, 0, 5'h1E, 0, 1, 1, 1);
        tbl[8]  = mk(8'h77, 1, 5'h1F, 1, 1, 3, 0, 0, 0, 5'h17, 0, 1, 1, 1);
        tbl[9]  = mk(8'h10, 0, 5'h1F, 1, 1, 3, 1, 0, 0, 5'h17, 0, 1, 1, 1);
        tbl[10] = mk(8'h77, 1, 5'h1F, 1, 0, 3, 0, 0, 0, 5'h1F, 1, 0, 0, 1);
        tbl[11] = mk(8'h77, 1, 5'h1F, 1, 1, 6, 0, 0, 0, 5'h1F, 1, 0, 0, 1);
        tbl[12] = mk(8'h3F, 1, 5'h1D, 0, 0, 0, 1, 2, 1, 5'h1D, 0, 1, 1, 0);
        tbl[13] = mk(8'h31, 1, 5'h1E, 0, 0, 0, 1, 2, 1, 5'h1D, 0, 1, 1, 1);
        tbl[14] = mk(8'h77, 1, 5'h17, 1, 1, 3, 0, 0, 0, 5'h17, 0, 1, 1, 0);

        #12;
        check_idle("reset");
        check("reset io_r_w_", 32'(io_r_w_), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default catch-all before any configuration.
        run_vec(100, mk(8'h55, 1, 5'h1F, 0, 0, 0, 1, 0, 0, 5'h1E, 0, 1, 1, 1));

        for (int i = 0; i < 4; i++) begin
            logic [7:0] base_t [4];
            logic [7:0] mask_t [4];
            logic [7:0] slot_t [4];
            logic [7:0] op_t   [4];
            base_t = '{8'h10, 8'h20, 8'h30, 8'h00};
            mask_t = '{8'hFF, 8'hF0, 8'hF0, 8'hFF};
            slot_t = '{8'h00, 8'h01, 8'h01, 8'h00};
            op_t   = '{8'hFF, 8'h00, 8'h01, 8'hFF};
            cfg_write(8'(i),      base_t[i]);
            cfg_write(8'(4 + i),  mask_t[i]);
            cfg_write(8'(8 + i),  slot_t[i]);
            cfg_write(8'(12 + i), op_t[i]);
        end
        // Address in the IRQ block range must not touch the windows.
        cfg_write(8'hC0, 8'h55);

        for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

        // Wait states: slot 1 busy for several clocks, then released mid-cycle.
        @(negedge clk);
        addr = 8'h31; r_w_ = 1'b1; dev_ready_n = 5'h1D; iorq_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("wait%0d ready_n", k), 32'(ready_n), 32'd0);
            check($sformatf("wait%0d cs_n", k), 32'(cs_n), 32'h1D);
            check($sformatf("wait%0d data_dir", k), 32'(data_dir), 32'd1);
        end
        @(negedge clk);
        dev_ready_n = 5'h1F;
        #1;
        check("release ready_n", 32'(ready_n), 32'd1);
        iorq_n = 1'b1;
        @(posedge clk); #1;
        check("release cs_n", 32'(cs_n), 32'h1F);

        // Cfg write during an active cycle leaves the latched slot alone.
        @(negedge clk);
        addr = 8'h25; r_w_ = 1'b0; iorq_n = 1'b0;
        @(posedge clk); #1;
        check("cfgmid cs_n before", 32'(cs_n), 32'h1D);
        cfg_write(8'h09, 8'h02);
        #1;
        check("cfgmid cs_n after", 32'(cs_n), 32'h1D);
        check("cfgmid new sel_slot", 32'(sel_slot), 32'd2);
        @(negedge clk);
        iorq_n = 1'b1;
        @(posedge clk); #1;
        check("cfgmid end cs_n", 32'(cs_n), 32'h1F);

        // Reset in the middle of a cycle forces idle outputs and restores the catch-all.
        @(negedge clk);
        addr = 8'h31; r_w_ = 1'b1; iorq_n = 1'b0;
        @(posedge clk); #1;
        check("rstmid cs_n active", 32'(cs_n), 32'h1D);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("rstmid");
        @(negedge clk);
        iorq_n = 1'b1;
        rst_n = 1'b1;
        run_vec(101, mk(8'h55, 1, 5'h1F, 0, 0, 0, 1, 0, 0, 5'h1E, 0, 1, 1, 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
